// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants and helpers for the four-decade BCD scan counter.
package bcd_scan_counter_pkg;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = $clog2(NUM_DIGITS);

  typedef logic [3:0] bcd_t;

  // Non-decimal nibbles (A..F) are loaded as zero so a digit never leaves 0..9.
  function automatic bcd_t sanitize_digit(input bcd_t d);
    return (d > BCD_MAX) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: synchronous clear/load, up/down step on carry-in, ripple carry-out.
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic load_i,
  input  bcd_t load_val_i,
  input  logic up_i,
  input  logic cin_i,
  output bcd_t digit_o,
  output logic cout_o
);

  bcd_t digit_q, digit_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = sanitize_digit(load_val_i);
    end else if (cin_i) begin
      if (up_i) digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      else      digit_d = (digit_q == 4'd0)    ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  assign digit_o = digit_q;
  assign cout_o  = cin_i & (up_i ? (digit_q == BCD_MAX) : (digit_q == 4'd0));

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with prescaled count tick, wrap pulse and
// a free-running digit scanner feeding a multiplexed display.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int SCAN_DIV = 1000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    EN,
  input  logic                    UP,
  input  logic                    CLEAR,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] LOAD_VALUE,
  output logic [4*NUM_DIGITS-1:0] COUNT,
  output logic                    CARRY,
  output logic [3:0]              NUMBER,
  output logic [NUM_DIGITS-1:0]   DIGIT_SEL
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [SW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic             carry_q;
  logic             tick;
  logic [NUM_DIGITS:0] chain;

  // CLEAR and LOAD both win over a pending tick, so the digits never see it.
  assign tick = EN & (presc_q == PRE_LAST) & ~CLEAR & ~LOAD;

  always_comb begin
    presc_d = presc_q;
    if (CLEAR || LOAD)  presc_d = '0;
    else if (tick)      presc_d = '0;
    else if (EN)        presc_d = presc_q + PW'(1);
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q    <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      carry_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      carry_q    <= chain[NUM_DIGITS];
    end
  end

  // Ripple chain: each decade steps when every lower decade wraps on this tick.
  assign chain[0] = tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .clear_i    (CLEAR),
      .load_i     (LOAD),
      .load_val_i (LOAD_VALUE[4*g +: 4]),
      .up_i       (UP),
      .cin_i      (chain[g]),
      .digit_o    (COUNT[4*g +: 4]),
      .cout_o     (chain[g+1])
    );
  end

  assign CARRY     = carry_q;
  assign DIGIT_SEL = NUM_DIGITS'(1) << scan_idx_q;
  assign NUMBER    = COUNT[{scan_idx_q, 2'b00} +: 4];

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter: integer-valued reference model
// feeding a per-cycle scoreboard, plus scenario-specific checks.
module tb_bcd_scan_counter;

  localparam int PRESCALE = 4;
  localparam int SCAN_DIV = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        EN = 1'b0, UP = 1'b1, CLEAR = 1'b0, LOAD = 1'b0;
  logic [15:0] LOAD_VALUE = 16'h0000;
  logic [15:0] COUNT;
  logic        CARRY;
  logic [3:0]  NUMBER;
  logic [3:0]  DIGIT_SEL;

  bcd_scan_counter #(.PRESCALE(PRESCALE), .SCAN_DIV(SCAN_DIV)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .EN         (EN),
    .UP         (UP),
    .CLEAR      (CLEAR),
    .LOAD       (LOAD),
    .LOAD_VALUE (LOAD_VALUE),
    .COUNT      (COUNT),
    .CARRY      (CARRY),
    .NUMBER     (NUMBER),
    .DIGIT_SEL  (DIGIT_SEL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] count;
    logic        carry;
    logic [3:0]  sel;
    logic [3:0]  number;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: count kept as a plain integer 0..9999.
  int m_val, m_pre, m_div, m_idx;
  bit m_carry;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      r = r * 10 + d;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_div = 0; m_idx = 0; m_carry = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit up, input bit clr, input bit ld,
                            input logic [15:0] lv);
    m_carry = 1'b0;
    if (clr) begin
      m_val = 0; m_pre = 0;
    end else if (ld) begin
      m_val = from_load(lv); m_pre = 0;
    end else if (en) begin
      if (m_pre == PRESCALE - 1) begin
        m_pre = 0;
        if (up) begin
          if (m_val == 9999) begin m_val = 0; m_carry = 1'b1; end
          else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin m_val = 9999; m_carry = 1'b1; end
          else m_val = m_val - 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    if (m_div == SCAN_DIV - 1) begin
      m_div = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_div = m_div + 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic [15:0] c;
    c        = to_bcd(m_val);
    e.count  = c;
    e.carry  = m_carry;
    e.sel    = 4'b0001 << m_idx;
    e.number = c[4*m_idx +: 4];
    return e;
  endfunction

  // One clock: drive inputs at the falling edge, queue the model's expectation,
  // then pop and compare just after the rising edge.
  task automatic drive_cycle(input bit en, input bit up, input bit clr, input bit ld,
                             input logic [15:0] lv);
    exp_t got, exp;
    @(negedge CLK);
    EN = en; UP = up; CLEAR = clr; LOAD = ld; LOAD_VALUE = lv;
    model_step(en, up, clr, ld, lv);
    sb_q.push_back(model_out());
    @(posedge CLK);
    #1;
    got = {COUNT, CARRY, DIGIT_SEL, NUMBER};
    exp = sb_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL scoreboard t=%0t: got count=%h carry=%b sel=%b num=%h, want count=%h carry=%b sel=%b num=%h",
               $time, got.count, got.carry, got.sel, got.number,
               exp.count, exp.carry, exp.sel, exp.number);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string name);
    #2 RESET = 1'b1;
    model_reset();
    #1;
    total++;
    if (COUNT !== 16'h0000 || CARRY !== 1'b0 || DIGIT_SEL !== 4'b0001 || NUMBER !== 4'h0) begin
      bad++;
      $display("FAIL %s: got count=%h carry=%b sel=%b num=%h, want count=0000 carry=0 sel=0001 num=0",
               name, COUNT, CARRY, DIGIT_SEL, NUMBER);
    end
    RESET = 1'b0;
  endtask

  task automatic check_count(input string name, input logic [15:0] want);
    total++;
    if (COUNT !== want) begin
      bad++;
      $display("FAIL %s: got count=%h, want %h", name, COUNT, want);
    end
  endtask

  task automatic test_reset();
    #1 RESET = 1'b1;
    model_reset();
    #1;
    total++;
    if (COUNT !== 16'h0000 || CARRY !== 1'b0 || DIGIT_SEL !== 4'b0001 || NUMBER !== 4'h0) begin
      bad++;
      $display("FAIL reset_initial: got count=%h carry=%b sel=%b num=%h, want 0000 0 0001 0",
               COUNT, CARRY, DIGIT_SEL, NUMBER);
    end
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b0;
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0120);
    repeat (12) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_count("count_to_0123", 16'h0123);
    repeat (2) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    pulse_reset("reset_midcount");
  endtask

  task automatic test_count_up();
    int carries = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      if (CARRY === 1'b1) carries++;
    end
    check_count("count_up_40", 16'h0010);
    total++;
    if (carries != 0) begin
      bad++;
      $display("FAIL count_up_carry: got %0d carry cycles, want 0", carries);
    end
  endtask

  task automatic test_wrap_up();
    int carries = 0;
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998);
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      if (CARRY === 1'b1) carries++;
      if (i == 4) check_count("wrap_up_9999", 16'h9999);
      if (i == 8) check_count("wrap_up_0000", 16'h0000);
    end
    total++;
    if (carries != 1) begin
      bad++;
      $display("FAIL wrap_up_carry: got %0d carry cycles, want 1", carries);
    end
  endtask

  task automatic test_wrap_down();
    int carries = 0;
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      if (CARRY === 1'b1) carries++;
      if (i == 4) check_count("wrap_down_9999", 16'h9999);
    end
    total++;
    if (carries != 1) begin
      bad++;
      $display("FAIL wrap_down_carry: got %0d carry cycles, want 1", carries);
    end
  endtask

  task automatic test_clear_load();
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555);
    check_count("clear_beats_load", 16'h0000);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h12A4);
    check_count("load_sanitize_12A4", 16'h1204);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'hFB9C);
    check_count("load_sanitize_FB9C", 16'h0090);
    // A load on the would-be tick edge suppresses the tick.
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0777);
    check_count("load_beats_tick", 16'h0777);
  endtask

  task automatic test_up_sample();
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0500);
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b1, (i % 2 == 0) ? (i != 8) : (i == 7 ? 1'b0 : 1'b1), 1'b0, 1'b0, 16'h0000);
      if (i == 4) check_count("up_sampled_tick1", 16'h0501);
      if (i == 8) check_count("up_sampled_tick2", 16'h0500);
    end
  endtask

  task automatic test_scan();
    logic [3:0] want_num [9] = '{4'h4, 4'h3, 4'h3, 4'h2, 4'h2, 4'h1, 4'h1, 4'h4, 4'h4};
    logic [3:0] want_sel [9] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    @(posedge CLK);
    pulse_reset("reset_before_scan");
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, (i == 0), 16'h1234);
      total++;
      if (NUMBER !== want_num[i] || DIGIT_SEL !== want_sel[i]) begin
        bad++;
        $display("FAIL scan_step%0d: got num=%h sel=%b, want num=%h sel=%b",
                 i, NUMBER, DIGIT_SEL, want_num[i], want_sel[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [15:0] lv;
      case ($urandom_range(0, 3))
        0:       lv = 16'h9997;
        1:       lv = 16'h0002;
        default: lv = 16'($urandom);
      endcase
      drive_cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 59) == 0,
                  $urandom_range(0, 24) == 0, lv);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_clear_load();
    test_up_sample();
    test_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000: CLK cycles per count tick while EN is high (minimum 1).
REQ-002 SHALL have parameter SCAN_DIV, default 1000: CLK cycles per display-digit advance (minimum 1).
REQ-003 SHALL have port CLK  in  1  single system clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port EN  in  1  prescaler/count enable.
REQ-006 SHALL have port UP  in  1  count direction: 1 = up, 0 = down.
REQ-007 SHALL have port CLEAR  in  1  synchronous clear of count and prescaler.
REQ-008 SHALL have port LOAD  in  1  synchronous load of LOAD_VALUE.
REQ-009 SHALL have port LOAD_VALUE  in  16  four packed BCD digits, digit 0 in [3:0].
REQ-010 SHALL have port COUNT  out  16  current four-digit packed-BCD count.
REQ-011 SHALL have port CARRY  out  1  one-cycle wrap/borrow pulse.
REQ-012 SHALL have port NUMBER  out  4  BCD value of the currently scanned digit, for the binary-to-display converter stage.
REQ-013 SHALL have port DIGIT_SEL  out  4  one-hot, active-high select of the scanned digit.

Function
REQ-014 SHALL run a prescaler counting 0..PRESCALE-1 only while EN=1, holding its value when EN=0; the tick condition is EN=1 and prescaler = PRESCALE-1; the prescaler then returns to 0.
REQ-015 SHALL, on the edge where tick is true, increment COUNT (UP=1) or decrement it (UP=0) by one in decimal, with per-digit 9->0 carry up and 0->9 borrow down.
REQ-016 SHALL wrap 9999->0000 when counting up and 0000->9999 when counting down, and SHALL drive CARRY high for exactly the one cycle following that edge; CARRY is 0 otherwise.
REQ-017 SHALL apply priority CLEAR > LOAD > tick within a cycle; CLEAR and LOAD both zero the prescaler and suppress the tick and CARRY for that cycle.
REQ-018 SHALL load each LOAD_VALUE digit greater than 9 as 0; valid digits are loaded unchanged.
REQ-019 SHALL sample UP on the tick edge only; changing UP between ticks has no other effect.
REQ-020 SHALL run a free-running scan divider (independent of EN, CLEAR, LOAD) that advances scan index 0->1->2->3->0 every SCAN_DIV cycles.
REQ-021 SHALL drive DIGIT_SEL bit i high for scan index i, and NUMBER = COUNT[4i+3:4i] combinationally from the registered index and COUNT (no added latency).

Reset
REQ-022 SHALL, while RESET=1, immediately force COUNT=16'h0000, CARRY=0, prescaler=0, scan divider=0, scan index=0 (DIGIT_SEL=4'b0001, NUMBER=4'h0), independent of CLK.
REQ-023 SHALL resume normal operation on the first rising CLK edge after RESET deasserts, with the prescaler starting from 0; reset mid-count discards any partial prescale.

Structure
REQ-024 SHALL take BCD_MAX (4'd9) and NUM_DIGITS (4) from the team's shared constants include.
REQ-025 SHALL implement each decade as a sub-module bcd_digit (load, clear, up/down, carry-in, carry-out), instantiated four times in a ripple chain.
REQ-026 SHALL keep the prescaler, scan divider and CARRY register in the top level.

Verification (PRESCALE=4, SCAN_DIV=2)
REQ-027 SHALL cover: COUNT=0x0123 counting, RESET pulsed between edges -> COUNT=0x0000, CARRY=0, DIGIT_SEL=0001 before the next edge.
REQ-028 SHALL cover: reset, EN=1, UP=1 for 40 cycles -> COUNT=0x0010 (10 ticks), CARRY never high.
REQ-029 SHALL cover: LOAD 0x9998, UP=1, EN=1 -> 0x9999 after 4 cycles, 0x0000 after 8, CARRY high for exactly one cycle.
REQ-030 SHALL cover: from 0x0000, UP=0, EN=1 for 4 cycles -> COUNT=0x9999, one-cycle CARRY pulse.
REQ-031 SHALL cover: CLEAR and LOAD(0x5555) in same cycle -> COUNT=0x0000; then LOAD 0x12A4 -> COUNT=0x1204.
REQ-032 SHALL cover: COUNT=0x1234, EN=0 -> NUMBER sequence 4,3,2,1,4 with DIGIT_SEL 0001,0010,0100,1000,0001, each held 2 cycles.
